ldpc_3gpp_dec_obuf_ctrl: RTL and testbench
==========================================

LDPC_3GPP_DEC_OBUF_CTRL -- requirements
Module: ldpc_3gpp_dec_obuf_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- pBNUM, 2, number of output memory banks; power of two, 2..8.
- pTAG_W, 4, tag width.
- pERR_W, 16, error-count width.
- cBSEL_W = clogb2(pBNUM), derived, bank index width; minimum 1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- iclk, in, 1, the single clock.
- ireset, in, 1, synchronous, active-high reset.
- iclkena, in, 1, clock enable; all state holds when low.
- iwdone, in, 1, single-cycle pulse: the decoder has finished writing bank owsel.
- iwtag, in, pTAG_W, context for the bank being released.
- iwdecfail, in, 1, context for the bank being released.
- iwerr, in, pERR_W, context for the bank being released.
- owsel, out, cBSEL_W, bank the decoder writes next.
- owfull, out, 1, no free bank; the decoder must not start a block.
- owovf, out, 1, single-cycle pulse: iwdone arrived while owfull was high.
- orfull, out, 1, at least one written bank is pending; drives the sink irfull.
- orsel, out, cBSEL_W, bank the sink reads; drives the sink bank mux or address MSBs.
- ortag, out, pTAG_W, context of bank orsel.
- ordecfail, out, 1, context of bank orsel.
- orerr, out, pERR_W, context of bank orsel.
- irempty, in, 1, single-cycle pulse from the sink orempty: bank orsel is released.
- oused, out, cBSEL_W+1, number of written, unreleased banks.

Function
REQ-003 The block SHALL manage the banks as a circular queue using three registers:
- wptr (cBSEL_W bits),
- rptr (cBSEL_W bits),
- used (cBSEL_W+1 bits).

REQ-004 All state SHALL update only on rising iclk edges where iclkena is high.

REQ-005 Combinational output mapping:
- owsel = wptr.
- orsel = rptr.
- oused = used.
- owfull = (used == pBNUM).
- orfull = (used != 0).

REQ-006 Write accept = iwdone & ~owfull. On accept:
- ctx[wptr] <= {iwtag, iwdecfail, iwerr}.
- wptr <= wptr+1, wrapping modulo pBNUM.

REQ-007 Read accept = irempty & orfull. On accept, rptr <= rptr+1, wrapping modulo pBNUM.

REQ-008 Counter update:
- used increments on write accept only.
- used decrements on read accept only.
- used is unchanged when both accepts occur in the same cycle; both pointers still advance.

REQ-009 Simultaneous iwdone and irempty while owfull=1: the read is accepted, the write is rejected, and owovf pulses. There is no same-cycle bypass.

REQ-010 iwdone while owfull=1 SHALL be ignored (no state change except owovf=1 for one cycle). owovf SHALL be registered: asserted in the cycle after the offending iwdone.

REQ-011 irempty while orfull=0 SHALL be ignored silently.

REQ-012 ortag, ordecfail and orerr SHALL equal ctx[rptr] combinationally. They are valid whenever orfull=1 and undefined otherwise.

REQ-013 Latency: an accepted iwdone at edge n SHALL make orfull=1 and oused updated visible after edge n. The sink therefore sees irfull in the cycle following the write.

REQ-014 After the last pending bank is released at edge n, orfull SHALL be 0 after edge n. This ensures the sink, back in its reset state at n+1, does not restart on a stale full flag.

REQ-015 ctx storage SHALL be flops, pBNUM entries of pTAG_W+1+pERR_W bits. Unwritten entries are not cleared.

REQ-016 The block SHALL NOT constrain sink read order. Banks are always released in write order (FIFO).

Reset
REQ-017 With ireset=1 at a rising edge (regardless of iclkena), the block SHALL set:
- wptr = 0, rptr = 0, used = 0, owovf = 0.
- Resulting outputs: owfull=0, orfull=0, owsel=0, orsel=0, oused=0.

REQ-018 Reset mid-operation SHALL discard all pending banks and their context. Any iwdone or irempty in the reset cycle SHALL be ignored.

REQ-019 The ctx array SHALL NOT be reset.

Verification
REQ-020 Single block (pBNUM=2):
- Stimulus: iwdone with iwtag=5, iwerr=3, iwdecfail=1.
- Next cycle: orfull=1, orsel=0, ortag=5, orerr=3, ordecfail=1, owsel=1, oused=1.
- Then irempty -> next cycle: orfull=0, oused=0, orsel=1.

REQ-021 Fill and overflow (pBNUM=2):
- Two iwdone pulses (tags 1, 2) -> owfull=1, oused=2.
- Third iwdone (tag 3) -> owovf=1 for one cycle, oused stays 2, ortag stays 1.

REQ-022 Simultaneous events:
- From oused=1, iwdone and irempty in the same cycle -> oused=1, orsel and owsel both advanced, ortag = new tag.
- From oused=2 the same stimulus -> oused=1, owovf=1.

REQ-023 Wrap-around (pBNUM=4):
- Stimulus: 10 write/read pairs, tags 0..9.
- Required: orsel sequence 0,1,2,3,0,1,2,3,0,1; ortag matches write order; oused never exceeds 4.

REQ-024 Clock enable and reset:
- iwdone with iclkena=0 -> no change.
- ireset during oused=2 with iclkena=0 -> oused=0, orfull=0 next cycle.
- Spurious irempty while empty -> no change.

Source files
------------

// File: rtl/ldpc_3gpp_dec_obuf_ctrl.sv
// Output-buffer bank controller: circular queue of pBNUM banks between LDPC decoder (writer) and sink (reader).
// Latency: a released bank is visible to the sink (orfull/oused/ctx) one cycle after iwdone; owovf is registered (+1 cycle).
// Backpressure: owfull stalls the decoder; iwdone while full is dropped and flagged by owovf, irempty while empty is ignored.
module ldpc_3gpp_dec_obuf_ctrl #(
    parameter int pBNUM  = 2,
    parameter int pTAG_W = 4,
    parameter int pERR_W = 16,
    localparam int cBSEL_W = (pBNUM <= 2) ? 1 : $clog2(pBNUM)
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               iwdone,
    input  logic [pTAG_W-1:0]  iwtag,
    input  logic               iwdecfail,
    input  logic [pERR_W-1:0]  iwerr,
    output logic [cBSEL_W-1:0] owsel,
    output logic               owfull,
    output logic               owovf,
    output logic               orfull,
    output logic [cBSEL_W-1:0] orsel,
    output logic [pTAG_W-1:0]  ortag,
    output logic               ordecfail,
    output logic [pERR_W-1:0]  orerr,
    input  logic               irempty,
    output logic [cBSEL_W:0]   oused
);

    localparam int cCTX_W = pTAG_W + 1 + pERR_W;

    logic [cBSEL_W-1:0] wptr;
    logic [cBSEL_W-1:0] rptr;
    logic [cBSEL_W:0]   used;
    logic               ovf;
    logic               wr_acc;
    logic               rd_acc;
    logic [cCTX_W-1:0]  ctx [pBNUM];

    // Status flags are pure decodes of the occupancy counter, so they track it with no extra delay.
    assign owfull = (used == (cBSEL_W+1)'(pBNUM));
    assign orfull = (used != '0);
    assign owsel  = wptr;
    assign orsel  = rptr;
    assign oused  = used;
    assign owovf  = ovf;

    // A write is only taken into a free bank; a read only releases a bank that actually holds data.
    assign wr_acc = iwdone & ~owfull;
    assign rd_acc = irempty & orfull;

    // Context of the bank under read is presented combinationally; stale when orfull is low.
    assign {ortag, ordecfail, orerr} = ctx[rptr];

    // Queue pointers, occupancy and overflow flag; reset wins over the clock enable.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            wptr <= '0;
            rptr <= '0;
            used <= '0;
            ovf  <= 1'b0;
        end else if (iclkena) begin
            // pBNUM is a power of two, so natural pointer overflow gives the modulo wrap.
            if (wr_acc) begin
                wptr <= wptr + cBSEL_W'(1);
            end
            if (rd_acc) begin
                rptr <= rptr + cBSEL_W'(1);
            end
            // Simultaneous accept leaves occupancy unchanged while both pointers move.
            case ({wr_acc, rd_acc})
                2'b10:   used <= used + (cBSEL_W+1)'(1);
                2'b01:   used <= used - (cBSEL_W+1)'(1);
                default: used <= used;
            endcase
            // Rejected write: read freeing a bank in the same cycle does not rescue it.
            ovf <= iwdone & owfull;
        end
    end

    // Per-bank context capture; storage is never cleared, validity comes from the occupancy count.
    always_ff @(posedge iclk) begin
        if (!ireset && iclkena && wr_acc) begin
            ctx[wptr] <= {iwtag, iwdecfail, iwerr};
        end
    end

endmodule

// File: tb/tb_ldpc_3gpp_dec_obuf_ctrl.sv
// Bench for the output-buffer bank controller: two instances (2 and 4 banks) driven by shared inputs.
// Directed table rows plus a wrap sequence, then random traffic, all against a queue-based reference model.
// Every cycle both instances are compared with the model; table rows add hand-derived constants.
module tb_ldpc_3gpp_dec_obuf_ctrl;

    typedef struct packed {
        logic [3:0]  tag;
        logic        df;
        logic [15:0] err;
    } ctx_t;

    typedef ctx_t ctxq_t[$];

    typedef struct {
        bit       rst, ena, wd, re;
        logic [3:0] tag;
        int       used, wsel, rsel;
        bit       full, rfull, ovf, ct;
        logic [3:0] etag;
    } vec_t;

    logic        iclk = 1'b0;
    logic        ireset, iclkena, iwdone, irempty, iwdecfail;
    logic [3:0]  iwtag;
    logic [15:0] iwerr;

    logic [0:0]  owsel2, orsel2;
    logic        owfull2, owovf2, orfull2, ordecfail2;
    logic [3:0]  ortag2;
    logic [15:0] orerr2;
    logic [1:0]  oused2;

    logic [1:0]  owsel4, orsel4;
    logic        owfull4, owovf4, orfull4, ordecfail4;
    logic [3:0]  ortag4;
    logic [15:0] orerr4;
    logic [2:0]  oused4;

    int nchecks = 0;
    int nerrors = 0;

    ctxq_t q2, q4;
    int    wc2, rc2, wc4, rc4;
    bit    ovf2, ovf4;

    vec_t tv[17];

    always #5 iclk = ~iclk;

    ldpc_3gpp_dec_obuf_ctrl #(.pBNUM(2), .pTAG_W(4), .pERR_W(16)) dut2 (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iwdone(iwdone),
        .iwtag(iwtag), .iwdecfail(iwdecfail), .iwerr(iwerr),
        .owsel(owsel2), .owfull(owfull2), .owovf(owovf2), .orfull(orfull2),
        .orsel(orsel2), .ortag(ortag2), .ordecfail(ordecfail2), .orerr(orerr2),
        .irempty(irempty), .oused(oused2)
    );

    ldpc_3gpp_dec_obuf_ctrl #(.pBNUM(4), .pTAG_W(4), .pERR_W(16)) dut4 (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iwdone(iwdone),
        .iwtag(iwtag), .iwdecfail(iwdecfail), .iwerr(iwerr),
        .owsel(owsel4), .owfull(owfull4), .owovf(owovf4), .orfull(orfull4),
        .orsel(orsel4), .ortag(ortag4), .ordecfail(ordecfail4), .orerr(orerr4),
        .irempty(irempty), .oused(oused4)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: a bank queue with write/read counters; bank numbers are counters modulo nb.
    task automatic model_upd(input int nb, inout ctxq_t q, inout int wc, inout int rc, inout bit ovf);
        bit full, nonempty;
        ctx_t c;
        if (ireset) begin
            q.delete();
            wc  = 0;
            rc  = 0;
            ovf = 1'b0;
        end else if (iclkena) begin
            full     = (q.size() == nb);
            nonempty = (q.size() != 0);
            ovf      = iwdone && full;
            if (irempty && nonempty) begin
                void'(q.pop_front());
                rc++;
            end
            if (iwdone && !full) begin
                c.tag = iwtag;
                c.df  = iwdecfail;
                c.err = iwerr;
                q.push_back(c);
                wc++;
            end
        end
    endtask

    task automatic cmp(input string p, input int nb, input ctxq_t q, input int wc, input int rc,
                       input bit ovf, input longint wsel, input longint rsel, input longint used,
                       input longint full, input longint rfull, input longint ovfo,
                       input longint tag, input longint df, input longint err);
        chk({p, " owsel"}, wsel, wc % nb);
        chk({p, " orsel"}, rsel, rc % nb);
        chk({p, " oused"}, used, q.size());
        chk({p, " owfull"}, full, (q.size() == nb) ? 1 : 0);
        chk({p, " orfull"}, rfull, (q.size() != 0) ? 1 : 0);
        chk({p, " owovf"}, ovfo, ovf ? 1 : 0);
        if (q.size() != 0) begin
            chk({p, " ortag"}, tag, q[0].tag);
            chk({p, " ordecfail"}, df, q[0].df);
            chk({p, " orerr"}, err, q[0].err);
        end
    endtask

    // One clock: inputs already set, advance past the edge, update model, compare both instances.
    task automatic step();
        @(posedge iclk);
        #1;
        model_upd(2, q2, wc2, rc2, ovf2);
        model_upd(4, q4, wc4, rc4, ovf4);
        cmp("d2", 2, q2, wc2, rc2, ovf2, owsel2, orsel2, oused2, owfull2, orfull2, owovf2,
            ortag2, ordecfail2, orerr2);
        cmp("d4", 4, q4, wc4, rc4, ovf4, owsel4, orsel4, oused4, owfull4, orfull4, owovf4,
            ortag4, ordecfail4, orerr4);
    endtask

    task automatic drive(input bit rst, input bit ena, input bit wd, input bit re, input logic [3:0] tag);
        ireset    = rst;
        iclkena   = ena;
        iwdone    = wd;
        irempty   = re;
        iwtag     = tag;
        iwdecfail = tag[0];
        iwerr     = {12'h0, tag} ^ 16'h0006;
    endtask

    function automatic vec_t mk(input bit rst, input bit ena, input bit wd, input bit re,
                                input int tag, input int used, input int wsel, input int rsel,
                                input bit full, input bit rfull, input bit ovf, input bit ct,
                                input int etag);
        vec_t v;
        v.rst = rst; v.ena = ena; v.wd = wd; v.re = re; v.tag = 4'(tag);
        v.used = used; v.wsel = wsel; v.rsel = rsel;
        v.full = full; v.rfull = rfull; v.ovf = ovf; v.ct = ct; v.etag = 4'(etag);
        return v;
    endfunction

    initial begin
        logic [3:0] et;
        logic [15:0] ee;

        // Rows target the 2-bank instance: rst ena wd re tag | used wsel rsel full rfull ovf chk_ctx tag
        tv[0]  = mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(0, 1, 1, 0, 5,  1, 1, 0, 0, 1, 0, 1, 5);   // single block: tag5 err3 decfail1
        tv[2]  = mk(0, 1, 0, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0);   // release -> empty, orsel advances
        tv[3]  = mk(0, 1, 1, 0, 1,  1, 0, 1, 0, 1, 0, 1, 1);
        tv[4]  = mk(0, 1, 1, 0, 2,  2, 1, 1, 1, 1, 0, 1, 1);   // full
        tv[5]  = mk(0, 1, 1, 0, 3,  2, 1, 1, 1, 1, 1, 1, 1);   // overflow pulse
        tv[6]  = mk(0, 1, 0, 0, 0,  2, 1, 1, 1, 1, 0, 1, 1);   // pulse lasts one cycle
        tv[7]  = mk(0, 1, 0, 1, 0,  1, 1, 0, 0, 1, 0, 1, 2);
        tv[8]  = mk(0, 1, 1, 1, 4,  1, 0, 1, 0, 1, 0, 1, 4);   // simultaneous at used=1
        tv[9]  = mk(0, 1, 1, 0, 6,  2, 1, 1, 1, 1, 0, 1, 4);
        tv[10] = mk(0, 1, 1, 1, 7,  1, 1, 0, 0, 1, 1, 1, 6);   // simultaneous while full
        tv[11] = mk(0, 1, 0, 0, 0,  1, 1, 0, 0, 1, 0, 1, 6);
        tv[12] = mk(0, 0, 1, 0, 8,  1, 1, 0, 0, 1, 0, 1, 6);   // clock enable low: no change
        tv[13] = mk(0, 1, 1, 0, 8,  2, 0, 0, 1, 1, 0, 1, 6);
        tv[14] = mk(1, 0, 1, 1, 9,  0, 0, 0, 0, 0, 0, 0, 0);   // reset with enable low, events ignored
        tv[15] = mk(0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);   // spurious release while empty
        tv[16] = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);

        q2.delete(); q4.delete();
        wc2 = 0; rc2 = 0; wc4 = 0; rc4 = 0; ovf2 = 1'b0; ovf4 = 1'b0;
        drive(1, 1, 0, 0, 4'h0);

        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].ena, tv[i].wd, tv[i].re, tv[i].tag);
            step();
            chk($sformatf("row%0d oused", i), oused2, tv[i].used);
            chk($sformatf("row%0d owsel", i), owsel2, tv[i].wsel);
            chk($sformatf("row%0d orsel", i), orsel2, tv[i].rsel);
            chk($sformatf("row%0d owfull", i), owfull2, tv[i].full);
            chk($sformatf("row%0d orfull", i), orfull2, tv[i].rfull);
            chk($sformatf("row%0d owovf", i), owovf2, tv[i].ovf);
            if (tv[i].ct) begin
                et = tv[i].etag;
                ee = {12'h0, et} ^ 16'h0006;
                chk($sformatf("row%0d ortag", i), ortag2, et);
                chk($sformatf("row%0d ordecfail", i), ordecfail2, et[0]);
                chk($sformatf("row%0d orerr", i), orerr2, ee);
            end
        end

        // Wrap-around on the 4-bank instance: ten write/release pairs with tags 0..9.
        drive(1, 1, 0, 0, 4'h0);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, 0, 4'(i));
            step();
            chk($sformatf("wrap%0d orsel", i), orsel4, i % 4);
            chk($sformatf("wrap%0d ortag", i), ortag4, i);
            chk($sformatf("wrap%0d oused<=4", i), (oused4 <= 3'd4) ? 1 : 0, 1);
            drive(0, 1, 0, 1, 4'h0);
            step();
            chk($sformatf("wrap%0d orsel after release", i), orsel4, (i + 1) % 4);
        end

        // Random traffic against the model, occasional reset and enable drop.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                  4'($urandom_range(0, 15)));
            iwdecfail = 1'($urandom_range(0, 1));
            iwerr     = 16'($urandom_range(0, 65535));
            step();
        end

        drive(0, 1, 0, 0, 4'h0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
